// File: rtl/mips_isa_pkg.sv
// MIPS ISA constants shared by the instruction encoder:
// op enum, opcode/funct fields, FSM states and word builders.
package mips_isa_pkg;

    typedef enum logic [4:0] {
        OP_SLL, OP_SRL, OP_SRA, OP_JR, OP_JALR,
        OP_ADD, OP_ADDU, OP_SUB, OP_SUBU,
        OP_AND, OP_OR, OP_XOR, OP_NOR,
        OP_SLT, OP_SLTU, OP_MUL, OP_BEQ,
        OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
        OP_ANDI, OP_LUI, OP_LW, OP_SW,
        OP_J, OP_JAL
    } op_e;

    localparam logic [5:0] OPC_SPECIAL  = 6'h00;
    localparam logic [5:0] OPC_SPECIAL2 = 6'h1C;
    localparam logic [5:0] OPC_J        = 6'h02;
    localparam logic [5:0] OPC_JAL      = 6'h03;
    localparam logic [5:0] OPC_BEQ      = 6'h04;
    localparam logic [5:0] OPC_ADDI     = 6'h08;
    localparam logic [5:0] OPC_ADDIU    = 6'h09;
    localparam logic [5:0] OPC_SLTI     = 6'h0A;
    localparam logic [5:0] OPC_SLTIU    = 6'h0B;
    localparam logic [5:0] OPC_ANDI     = 6'h0C;
    localparam logic [5:0] OPC_LUI      = 6'h0F;
    localparam logic [5:0] OPC_LW       = 6'h23;
    localparam logic [5:0] OPC_SW       = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;
    localparam logic [5:0] FN_MUL  = 6'h02;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_ERR
    } state_e;

    function automatic logic [31:0] rWord(
        input logic [5:0] opc,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic [4:0] rd,
        input logic [4:0] sh,
        input logic [5:0] fn
    );
        return {opc, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] iWord(
        input logic [5:0]  opc,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [15:0] imm
    );
        return {opc, rs, rt, imm};
    endfunction

    function automatic logic [31:0] jWord(
        input logic [5:0]  opc,
        input logic [25:0] tgt
    );
        return {opc, tgt};
    endfunction

endpackage

// File: rtl/inst_encode_comb.sv
// Pure combinational MIPS encoder: op + fields -> 32-bit word.
// Unused fields are forced to zero regardless of the inputs.
module inst_encode_comb
    import mips_isa_pkg::*;
(
    input  logic [4:0]  in_op,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_shamt,
    input  logic [15:0] in_imm,
    input  logic [25:0] in_target,
    output logic [31:0] encWord,
    output logic        encOk
);

    op_e        op;
    logic [5:0] funct;
    logic [5:0] iOpc;

    assign op = op_e'(in_op);

    always_comb begin
        funct = FN_SLL;
        unique case (op)
            OP_SLL:  funct = FN_SLL;
            OP_SRL:  funct = FN_SRL;
            OP_SRA:  funct = FN_SRA;
            OP_JR:   funct = FN_JR;
            OP_JALR: funct = FN_JALR;
            OP_ADD:  funct = FN_ADD;
            OP_ADDU: funct = FN_ADDU;
            OP_SUB:  funct = FN_SUB;
            OP_SUBU: funct = FN_SUBU;
            OP_AND:  funct = FN_AND;
            OP_OR:   funct = FN_OR;
            OP_XOR:  funct = FN_XOR;
            OP_NOR:  funct = FN_NOR;
            OP_SLT:  funct = FN_SLT;
            OP_SLTU: funct = FN_SLTU;
            default: funct = FN_SLL;
        endcase
    end

    always_comb begin
        iOpc = OPC_SPECIAL;
        unique case (op)
            OP_BEQ:   iOpc = OPC_BEQ;
            OP_ADDI:  iOpc = OPC_ADDI;
            OP_ADDIU: iOpc = OPC_ADDIU;
            OP_SLTI:  iOpc = OPC_SLTI;
            OP_SLTIU: iOpc = OPC_SLTIU;
            OP_ANDI:  iOpc = OPC_ANDI;
            OP_LUI:   iOpc = OPC_LUI;
            OP_LW:    iOpc = OPC_LW;
            OP_SW:    iOpc = OPC_SW;
            default:  iOpc = OPC_SPECIAL;
        endcase
    end

    always_comb begin
        encWord = '0;
        encOk   = 1'b1;
        unique case (op)
            OP_SLL, OP_SRL, OP_SRA:
                encWord = rWord(OPC_SPECIAL, 5'd0, in_rt,
                                in_rd, in_shamt, funct);
            OP_JR:
                encWord = rWord(OPC_SPECIAL, in_rs, 5'd0,
                                5'd0, 5'd0, funct);
            OP_JALR:
                encWord = rWord(OPC_SPECIAL, in_rs, 5'd0,
                                in_rd, 5'd0, funct);
            OP_ADD, OP_ADDU, OP_SUB, OP_SUBU,
            OP_AND, OP_OR, OP_XOR, OP_NOR,
            OP_SLT, OP_SLTU:
                encWord = rWord(OPC_SPECIAL, in_rs, in_rt,
                                in_rd, 5'd0, funct);
            OP_MUL:
                encWord = rWord(OPC_SPECIAL2, in_rs, in_rt,
                                in_rd, 5'd0, FN_MUL);
            OP_BEQ, OP_ADDI, OP_ADDIU, OP_SLTI,
            OP_SLTIU, OP_ANDI, OP_LW, OP_SW:
                encWord = iWord(iOpc, in_rs, in_rt, in_imm);
            OP_LUI:
                encWord = iWord(iOpc, 5'd0, in_rt, in_imm);
            OP_J:
                encWord = jWord(OPC_J, in_target);
            OP_JAL:
                encWord = jWord(OPC_JAL, in_target);
            default: begin
                encWord = '0;
                encOk   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// Instruction encoder: accepts an op request, encodes it and writes
// the word to memory at an auto-incrementing pointer.
module inst_encoder
    import mips_isa_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        base_load,
    input  logic [31:0] base_addr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_op,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_shamt,
    input  logic [15:0] in_imm,
    input  logic [25:0] in_target,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        err,
    output logic [15:0] word_count
);

    state_e      state;
    state_e      stateNext;
    logic [31:0] wrPtr;
    logic [31:0] encWord;
    logic        encOk;
    logic        accept;
    logic        ackDone;
    logic        unusedBase;

    assign unusedBase = ^base_addr[1:0];

    inst_encode_comb uEnc (
        .in_op     (in_op),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_rd     (in_rd),
        .in_shamt  (in_shamt),
        .in_imm    (in_imm),
        .in_target (in_target),
        .encWord   (encWord),
        .encOk     (encOk)
    );

    assign in_ready = (state == ST_IDLE) && !base_load;
    assign accept   = in_valid && in_ready;
    assign ackDone  = (state == ST_WRITE) && mem_ack;
    assign mem_req  = (state == ST_WRITE);
    assign err      = (state == ST_ERR);

    always_comb begin
        stateNext = state;
        unique case (state)
            ST_IDLE:
                if (accept)
                    stateNext = encOk ? ST_WRITE : ST_ERR;
            ST_WRITE:
                if (mem_ack)
                    stateNext = ST_IDLE;
            ST_ERR:
                stateNext = ST_IDLE;
            default:
                stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= ST_IDLE;
        else
            state <= stateNext;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr      <= '0;
            word_count <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            if (state == ST_IDLE && base_load)
                wrPtr <= {base_addr[31:2], 2'b00};
            if (accept && encOk) begin
                mem_addr  <= wrPtr;
                mem_wdata <= encWord;
            end
            // Pointer wraps naturally at 32 bits, count at 16.
            if (ackDone) begin
                wrPtr      <= wrPtr + 32'd4;
                word_count <= word_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Randomized self-checking bench for inst_encoder against
// an arithmetic reference of the MIPS encoding rules.
module tb_inst_encoder;

    logic        clk;
    logic        reset;
    logic        base_load;
    logic [31:0] base_addr;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_op;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [4:0]  in_shamt;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        mem_req;
    logic        mem_ack;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        err;
    logic [15:0] word_count;

    int          nCmp;
    int          nBad;
    logic [31:0] refPtr;
    logic [15:0] refCount;

    inst_encoder dut (
        .clk        (clk),
        .reset      (reset),
        .base_load  (base_load),
        .base_addr  (base_addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_rd      (in_rd),
        .in_shamt   (in_shamt),
        .in_imm     (in_imm),
        .in_target  (in_target),
        .mem_req    (mem_req),
        .mem_ack    (mem_ack),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .err        (err),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        nCmp++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: {supported, word} from the ISA tables.
    function automatic logic [32:0] refEncode(
        input int unsigned op,
        input int unsigned rs,
        input int unsigned rt,
        input int unsigned rd,
        input int unsigned sh,
        input int unsigned imm,
        input int unsigned tgt
    );
        int unsigned fnTab[15] = '{'h00, 'h02, 'h03, 'h08, 'h09,
                                   'h20, 'h21, 'h22, 'h23, 'h24,
                                   'h25, 'h26, 'h27, 'h2A, 'h2B};
        int unsigned opTab[9]  = '{'h04, 'h08, 'h09, 'h0A, 'h0B,
                                   'h0C, 'h0F, 'h23, 'h2B};
        int unsigned w;
        if (op <= 14) begin
            if (op <= 2) rs = 0;
            if (op == 3) begin rt = 0; rd = 0; end
            if (op == 4) rt = 0;
            if (op >= 3) sh = 0;
            w = rs * 2**21 + rt * 2**16 + rd * 2**11
              + sh * 2**6 + fnTab[op];
            return {1'b1, w};
        end
        if (op == 15) begin
            w = 'h1C * 2**26 + rs * 2**21 + rt * 2**16
              + rd * 2**11 + 2;
            return {1'b1, w};
        end
        if (op <= 24) begin
            if (op == 22) rs = 0;
            w = opTab[op - 16] * 2**26 + rs * 2**21
              + rt * 2**16 + imm;
            return {1'b1, w};
        end
        if (op <= 26) begin
            w = (op - 23) * 2**26 + tgt;
            return {1'b1, w};
        end
        return 33'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic loadBase(input logic [31:0] a);
        base_load = 1'b1;
        base_addr = a;
        in_valid  = 1'b0;
        #1;
        check("ready_low_on_load", in_ready, 0);
        tick();
        base_load = 1'b0;
        refPtr = {a[31:2], 2'b00};
    endtask

    task automatic doOp(
        input int unsigned op,
        input int unsigned rs,
        input int unsigned rt,
        input int unsigned rd,
        input int unsigned sh,
        input int unsigned imm,
        input int unsigned tgt,
        input int          ackDelay,
        input bit          ackTied,
        input bit          useFixed,
        input logic [31:0] fixedExp
    );
        logic [32:0] r;
        r = refEncode(op, rs, rt, rd, sh, imm, tgt);
        in_op     = op[4:0];
        in_rs     = rs[4:0];
        in_rt     = rt[4:0];
        in_rd     = rd[4:0];
        in_shamt  = sh[4:0];
        in_imm    = imm[15:0];
        in_target = tgt[25:0];
        in_valid  = 1'b1;
        mem_ack   = ackTied;
        #1;
        check("ready_before_accept", in_ready, 1);
        tick();
        in_valid = 1'b0;
        if (r[32]) begin
            check("req_after_accept", mem_req, 1);
            check("ready_in_write", in_ready, 0);
            check("addr", mem_addr, refPtr);
            check("wdata", mem_wdata, r[31:0]);
            check("no_err", err, 0);
            if (useFixed)
                check("wdata_fixed", mem_wdata, fixedExp);
            if (!ackTied) begin
                for (int i = 0; i < ackDelay; i++) begin
                    tick();
                    check("stall_req", mem_req, 1);
                    check("stall_ready", in_ready, 0);
                    check("stall_addr", mem_addr, refPtr);
                    check("stall_wdata", mem_wdata, r[31:0]);
                end
                mem_ack = 1'b1;
            end
            tick();
            mem_ack  = 1'b0;
            refPtr   = refPtr + 32'd4;
            refCount = refCount + 16'd1;
            check("req_done", mem_req, 0);
            check("ready_done", in_ready, 1);
            check("count", word_count, refCount);
        end else begin
            check("err_pulse", err, 1);
            check("err_no_req", mem_req, 0);
            tick();
            mem_ack = 1'b0;
            check("err_cleared", err, 0);
            check("err_no_req2", mem_req, 0);
            check("err_count", word_count, refCount);
            check("err_ready", in_ready, 1);
        end
    endtask

    initial begin
        nCmp      = 0;
        nBad      = 0;
        refPtr    = 32'd0;
        refCount  = 16'd0;
        reset     = 1'b0;
        base_load = 1'b0;
        base_addr = 32'd0;
        in_valid  = 1'b0;
        in_op     = 5'd0;
        in_rs     = 5'd0;
        in_rt     = 5'd0;
        in_rd     = 5'd0;
        in_shamt  = 5'd0;
        in_imm    = 16'd0;
        in_target = 26'd0;
        mem_ack   = 1'b0;
        #2;
        check("rst_req", mem_req, 0);
        check("rst_err", err, 0);
        check("rst_count", word_count, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("ready_after_rst", in_ready, 1);

        // Reset values and base load with unaligned address
        loadBase(32'h0040_0003);
        doOp(6, 1, 2, 3, 0, 0, 0, 0, 0, 1, 32'h0022_1821);
        check("t1_count", word_count, 1);

        // Encoding forms with ack tied high
        doOp(22, 5, 8, 0, 0, 'h1234, 0, 0, 1, 1, 32'h3C08_1234);
        doOp(0, 7, 4, 2, 3, 0, 0, 0, 1, 1, 32'h0004_10C0);
        doOp(26, 0, 0, 0, 0, 0, 'h010_0000, 0, 1, 1,
             32'h0C10_0000);
        doOp(15, 1, 2, 3, 0, 0, 0, 0, 1, 1, 32'h7022_1802);

        // Ack stall
        doOp(17, 3, 9, 0, 0, 'hBEEF, 0, 5, 0, 0, 32'd0);

        // Unsupported op, then verify pointer unchanged
        doOp(29, 1, 2, 3, 4, 5, 6, 0, 0, 0, 32'd0);
        doOp(5, 9, 10, 11, 0, 0, 0, 1, 0, 0, 32'd0);

        // Pointer wrap
        loadBase(32'hFFFF_FFFC);
        doOp(7, 1, 1, 1, 0, 0, 0, 0, 0, 0, 32'd0);
        check("wrap_ptr", refPtr, 32'd0);
        doOp(8, 2, 2, 2, 0, 0, 0, 0, 0, 0, 32'd0);

        // Collision: base_load and in_valid together
        base_load = 1'b1;
        base_addr = 32'h1000_0012;
        in_valid  = 1'b1;
        in_op     = 5'd6;
        #1;
        check("coll_ready", in_ready, 0);
        tick();
        check("coll_no_req", mem_req, 0);
        check("coll_no_err", err, 0);
        base_load = 1'b0;
        in_valid  = 1'b0;
        refPtr    = 32'h1000_0010;
        doOp(9, 4, 5, 6, 0, 0, 0, 0, 0, 0, 32'd0);

        // Reset mid-WRITE
        in_op    = 5'd6;
        in_valid = 1'b1;
        mem_ack  = 1'b0;
        tick();
        in_valid = 1'b0;
        check("pre_rst_req", mem_req, 1);
        reset = 1'b0;
        #1;
        check("midrst_req", mem_req, 0);
        check("midrst_count", word_count, 0);
        check("midrst_addr", mem_addr, 0);
        @(negedge clk);
        reset   = 1'b1;
        mem_ack = 1'b1;
        tick();
        tick();
        mem_ack = 1'b0;
        check("post_rst_req", mem_req, 0);
        check("post_rst_count", word_count, 0);
        refPtr   = 32'd0;
        refCount = 16'd0;

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0)
                loadBase($urandom);
            doOp($urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31), $urandom_range(0, 65535),
                 $urandom_range(0, 32'h3FF_FFFF),
                 int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'b0, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 nCmp, nBad);
        $finish;
    end

endmodule
